// File: rtl/sync_fifo_flags_if.sv
// +----------------------------------------------------------------------------+
// | Module      : sync_fifo_flags_if                                           |
// | Description : Write/read handshake and status bundle for sync_fifo_flags.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sync_fifo_flags_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic                  WR;
    logic                  RD;
    logic                  ClrErr;
    logic [DATA_WIDTH-1:0] dataIn;
    logic [DATA_WIDTH-1:0] dataOut;
    logic [LEVEL_W-1:0]    Level;
    logic                  EMPTY;
    logic                  FULL;
    logic                  ALMOST_EMPTY;
    logic                  ALMOST_FULL;
    logic                  OVERFLOW;
    logic                  UNDERFLOW;

    modport master (
        output WR, RD, ClrErr, dataIn,
        input  dataOut, Level, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL,
               OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  WR, RD, ClrErr, dataIn,
        output dataOut, Level, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL,
               OVERFLOW, UNDERFLOW
    );
endinterface

`default_nettype wire

// File: rtl/sync_fifo_flags.sv
// +----------------------------------------------------------------------------+
// | Module      : sync_fifo_flags                                              |
// | Description : Parametrised single-clock FIFO with level, threshold flags,  |
// |               sticky error flags and optional first-word-fall-through.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_fifo_flags #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    sync_fifo_flags_if.slave  bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    localparam logic [c_LVL_W-1:0] c_DEPTH  = c_LVL_W'(FIFO_DEPTH);
    localparam logic [c_LVL_W-1:0] c_AFULL  = c_LVL_W'(AFULL_THRESH);
    localparam logic [c_LVL_W-1:0] c_AEMPTY = c_LVL_W'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_LVL_W-1:0]    r_level;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_empty;
    logic w_full;
    logic w_wr_ok;
    logic w_rd_ok;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_DEPTH);
    assign w_wr_ok = bus.WR && !w_full;
    assign w_rd_ok = bus.RD && !w_empty;

    // Storage is deliberately left out of reset.
    always_ff @(posedge Clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= bus.dataIn;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // A new error in the same cycle as ClrErr keeps the flag set.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.WR && w_full) begin
                r_overflow <= 1'b1;
            end else if (bus.ClrErr) begin
                r_overflow <= 1'b0;
            end
            if (bus.RD && w_empty) begin
                r_underflow <= 1'b1;
            end else if (bus.ClrErr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.dataOut = w_empty ? '0 : r_mem[r_rd_ptr];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] r_data_out;

            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    r_data_out <= '0;
                end else if (w_rd_ok) begin
                    r_data_out <= r_mem[r_rd_ptr];
                end
            end

            assign bus.dataOut = r_data_out;
        end
    endgenerate

    assign bus.Level        = r_level;
    assign bus.EMPTY        = w_empty;
    assign bus.FULL         = w_full;
    assign bus.ALMOST_EMPTY = (r_level <= c_AEMPTY);
    assign bus.ALMOST_FULL  = (r_level >= c_AFULL);
    assign bus.OVERFLOW     = r_overflow;
    assign bus.UNDERFLOW    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_sync_fifo_flags                                           |
// | Description : Scoreboard bench for sync_fifo_flags, registered and FWFT.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sync_fifo_flags;
    localparam int c_DW    = 8;
    localparam int c_DEPTH = 16;
    localparam int c_AF    = 12;
    localparam int c_AE    = 4;

    logic Clk;
    logic rst0;
    logic rst1;

    int checks;
    int errors;

    // Scoreboards: contents each FIFO should hold, plus expected sticky flags.
    logic [c_DW-1:0] sb0[$];
    logic [c_DW-1:0] sb1[$];
    logic [c_DW-1:0] hold0;
    logic            ov0;
    logic            un0;

    sync_fifo_flags_if #(.DATA_WIDTH(c_DW), .FIFO_DEPTH(c_DEPTH)) bus0 ();
    sync_fifo_flags_if #(.DATA_WIDTH(c_DW), .FIFO_DEPTH(c_DEPTH)) bus1 ();

    sync_fifo_flags #(
        .DATA_WIDTH(c_DW), .FIFO_DEPTH(c_DEPTH),
        .AFULL_THRESH(c_AF), .AEMPTY_THRESH(c_AE), .FWFT(0)
    ) u_dut0 (
        .Clk (Clk),
        .Rst (rst0),
        .bus (bus0.slave)
    );

    sync_fifo_flags #(
        .DATA_WIDTH(c_DW), .FIFO_DEPTH(c_DEPTH),
        .AFULL_THRESH(c_AF), .AEMPTY_THRESH(c_AE), .FWFT(1)
    ) u_dut1 (
        .Clk (Clk),
        .Rst (rst1),
        .bus (bus1.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // One clock of stimulus on the registered FIFO; the model is updated from
    // the pre-edge occupancy and the popped word becomes the expected dataOut.
    task automatic drive0(input logic wr, input logic rd, input logic clr,
                          input logic [c_DW-1:0] din);
        logic wr_ok;
        logic rd_ok;
        wr_ok = wr && (sb0.size() != c_DEPTH);
        rd_ok = rd && (sb0.size() != 0);
        if (wr && sb0.size() == c_DEPTH) ov0 = 1'b1;
        else if (clr)                    ov0 = 1'b0;
        if (rd && sb0.size() == 0)       un0 = 1'b1;
        else if (clr)                    un0 = 1'b0;
        bus0.WR     = wr;
        bus0.RD     = rd;
        bus0.ClrErr = clr;
        bus0.dataIn = din;
        if (wr_ok) sb0.push_back(din);
        @(posedge Clk);
        #1;
        if (rd_ok) hold0 = sb0.pop_front();
        bus0.WR     = 1'b0;
        bus0.RD     = 1'b0;
        bus0.ClrErr = 1'b0;
    endtask

    task automatic test_reset();
        rst0 = 1'b1;
        rst1 = 1'b1;
        @(posedge Clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        sb0.delete();
        sb1.delete();
        hold0 = '0;
        ov0 = 1'b0;
        un0 = 1'b0;
        @(posedge Clk);
        #1;
        checks++;
        if ({bus0.EMPTY, bus0.ALMOST_EMPTY, bus0.FULL, bus0.ALMOST_FULL} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_flags0: got E/AE/F/AF=%b want 1100",
                     {bus0.EMPTY, bus0.ALMOST_EMPTY, bus0.FULL, bus0.ALMOST_FULL});
        end
        checks++;
        if (bus0.Level !== 5'd0 || bus0.dataOut !== 8'h00) begin
            errors++;
            $display("FAIL reset_level_data0: got level=%0d data=%h want 0/00", bus0.Level, bus0.dataOut);
        end
        checks++;
        if (bus0.OVERFLOW !== 1'b0 || bus0.UNDERFLOW !== 1'b0) begin
            errors++;
            $display("FAIL reset_err0: got ov=%b un=%b want 0/0", bus0.OVERFLOW, bus0.UNDERFLOW);
        end
        checks++;
        if (bus1.EMPTY !== 1'b1 || bus1.Level !== 5'd0 || bus1.dataOut !== 8'h00) begin
            errors++;
            $display("FAIL reset_fwft: got empty=%b level=%0d data=%h want 1/0/00",
                     bus1.EMPTY, bus1.Level, bus1.dataOut);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < c_DEPTH; i++) begin
            drive0(1'b1, 1'b0, 1'b0, c_DW'(i + 1));
            checks++;
            if (int'(bus0.Level) !== sb0.size() || bus0.ALMOST_FULL !== (i + 1 >= c_AF)
                || bus0.FULL !== (i + 1 == c_DEPTH)) begin
                errors++;
                $display("FAIL fill_%0d: got level=%0d af=%b full=%b want %0d/%b/%b", i,
                         bus0.Level, bus0.ALMOST_FULL, bus0.FULL, i + 1, (i + 1 >= c_AF), (i + 1 == c_DEPTH));
            end
        end
        for (int i = 0; i < c_DEPTH; i++) begin
            drive0(1'b0, 1'b1, 1'b0, '0);
            checks++;
            if (bus0.dataOut !== hold0 || bus0.dataOut !== c_DW'(i + 1)) begin
                errors++;
                $display("FAIL drain_data_%0d: got %h want %h", i, bus0.dataOut, hold0);
            end
            checks++;
            if (int'(bus0.Level) !== sb0.size() || bus0.ALMOST_EMPTY !== (sb0.size() <= c_AE)
                || bus0.EMPTY !== (sb0.size() == 0)) begin
                errors++;
                $display("FAIL drain_flags_%0d: got level=%0d ae=%b empty=%b want %0d/%b/%b", i,
                         bus0.Level, bus0.ALMOST_EMPTY, bus0.EMPTY, sb0.size(),
                         (sb0.size() <= c_AE), (sb0.size() == 0));
            end
        end
        drive0(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (bus0.dataOut !== 8'h10) begin
            errors++;
            $display("FAIL hold_when_empty: got %h want 10", bus0.dataOut);
        end
    endtask

    task automatic test_wrap();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 10; i++) begin
                drive0(1'b1, 1'b0, 1'b0, (pass == 0) ? c_DW'(8'hA0 + i) : c_DW'(8'hB0 + i));
            end
            for (int i = 0; i < 10; i++) begin
                drive0(1'b0, 1'b1, 1'b0, '0);
                checks++;
                if (bus0.dataOut !== hold0) begin
                    errors++;
                    $display("FAIL wrap_data_p%0d_%0d: got %h want %h", pass, i, bus0.dataOut, hold0);
                end
            end
        end
        checks++;
        if (bus0.Level !== 5'd0 || bus0.EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL wrap_level: got level=%0d empty=%b want 0/1", bus0.Level, bus0.EMPTY);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) drive0(1'b1, 1'b0, 1'b0, c_DW'(8'h20 + i));
        for (int i = 0; i < 8; i++) begin
            drive0(1'b1, 1'b1, 1'b0, c_DW'(8'h30 + i));
            checks++;
            if (bus0.Level !== 5'd5 || bus0.dataOut !== hold0) begin
                errors++;
                $display("FAIL simul_%0d: got level=%0d data=%h want 5/%h", i, bus0.Level, bus0.dataOut, hold0);
            end
        end
        while (sb0.size() < c_DEPTH) drive0(1'b1, 1'b0, 1'b0, c_DW'(8'h40 + sb0.size()));
        drive0(1'b1, 1'b1, 1'b0, 8'hEE);
        checks++;
        if (bus0.Level !== 5'd15 || bus0.OVERFLOW !== 1'b1 || bus0.dataOut !== hold0) begin
            errors++;
            $display("FAIL simul_full: got level=%0d ov=%b data=%h want 15/1/%h",
                     bus0.Level, bus0.OVERFLOW, bus0.dataOut, hold0);
        end
        drive0(1'b0, 1'b0, 1'b1, '0);
        while (sb0.size() > 0) begin
            drive0(1'b0, 1'b1, 1'b0, '0);
            checks++;
            if (bus0.dataOut !== hold0) begin
                errors++;
                $display("FAIL simul_drain: got %h want %h", bus0.dataOut, hold0);
            end
        end
        drive0(1'b1, 1'b1, 1'b0, 8'h77);
        checks++;
        if (bus0.Level !== 5'd1 || bus0.UNDERFLOW !== 1'b1 || bus0.OVERFLOW !== 1'b0) begin
            errors++;
            $display("FAIL simul_empty: got level=%0d un=%b ov=%b want 1/1/0",
                     bus0.Level, bus0.UNDERFLOW, bus0.OVERFLOW);
        end
        drive0(1'b0, 1'b1, 1'b1, '0);
        checks++;
        if (bus0.dataOut !== 8'h77 || bus0.EMPTY !== 1'b1 || bus0.UNDERFLOW !== un0) begin
            errors++;
            $display("FAIL simul_empty_pop: got data=%h empty=%b un=%b want 77/1/%b",
                     bus0.dataOut, bus0.EMPTY, bus0.UNDERFLOW, un0);
        end
    endtask

    task automatic test_errors();
        drive0(1'b0, 1'b1, 1'b0, '0);
        drive0(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (bus0.UNDERFLOW !== 1'b1 || bus0.Level !== 5'd0) begin
            errors++;
            $display("FAIL underflow_sticky: got un=%b level=%0d want 1/0", bus0.UNDERFLOW, bus0.Level);
        end
        drive0(1'b0, 1'b0, 1'b1, '0);
        checks++;
        if (bus0.UNDERFLOW !== un0 || un0 !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: got %b want 0", bus0.UNDERFLOW);
        end
        drive0(1'b0, 1'b1, 1'b1, '0);
        checks++;
        if (bus0.UNDERFLOW !== 1'b1) begin
            errors++;
            $display("FAIL underflow_set_wins: got %b want 1", bus0.UNDERFLOW);
        end
        drive0(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < c_DEPTH; i++) drive0(1'b1, 1'b0, 1'b0, c_DW'(8'hC0 + i));
        drive0(1'b1, 1'b0, 1'b1, 8'hFF);
        checks++;
        if (bus0.OVERFLOW !== 1'b1 || bus0.Level !== 5'd16) begin
            errors++;
            $display("FAIL overflow_set_wins: got ov=%b level=%0d want 1/16", bus0.OVERFLOW, bus0.Level);
        end
        drive0(1'b0, 1'b0, 1'b1, '0);
        checks++;
        if (bus0.OVERFLOW !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: got %b want 0", bus0.OVERFLOW);
        end
        // The rejected write must not have disturbed the stored words.
        for (int i = 0; i < c_DEPTH; i++) begin
            drive0(1'b0, 1'b1, 1'b0, '0);
            checks++;
            if (bus0.dataOut !== hold0) begin
                errors++;
                $display("FAIL overflow_intact_%0d: got %h want %h", i, bus0.dataOut, hold0);
            end
        end
    endtask

    task automatic test_fwft();
        bus1.WR = 1'b1;
        bus1.dataIn = 8'h55;
        sb1.push_back(8'h55);
        @(posedge Clk);
        #1;
        bus1.WR = 1'b0;
        checks++;
        if (bus1.dataOut !== 8'h55 || bus1.EMPTY !== 1'b0) begin
            errors++;
            $display("FAIL fwft_show: got data=%h empty=%b want 55/0", bus1.dataOut, bus1.EMPTY);
        end
        bus1.RD = 1'b1;
        @(posedge Clk);
        #1;
        bus1.RD = 1'b0;
        void'(sb1.pop_front());
        checks++;
        if (bus1.dataOut !== 8'h00 || bus1.EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL fwft_pop: got data=%h empty=%b want 00/1", bus1.dataOut, bus1.EMPTY);
        end
        for (int i = 0; i < 7; i++) begin
            bus1.WR = 1'b1;
            bus1.dataIn = c_DW'(8'h60 + i);
            sb1.push_back(bus1.dataIn);
            @(posedge Clk);
            #1;
        end
        bus1.WR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus1.dataOut !== sb1[0]) begin
                errors++;
                $display("FAIL fwft_head_%0d: got %h want %h", i, bus1.dataOut, sb1[0]);
            end
            bus1.RD = 1'b1;
            @(posedge Clk);
            #1;
            void'(sb1.pop_front());
        end
        bus1.RD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus1.WR = 1'b1;
            bus1.dataIn = c_DW'(8'h70 + i);
            sb1.push_back(bus1.dataIn);
            @(posedge Clk);
            #1;
        end
        bus1.WR = 1'b0;
        checks++;
        if (int'(bus1.Level) !== sb1.size() || bus1.dataOut !== sb1[0]) begin
            errors++;
            $display("FAIL fwft_level7: got level=%0d data=%h want %0d/%h",
                     bus1.Level, bus1.dataOut, sb1.size(), sb1[0]);
        end
        // Asynchronous reset mid-cycle must clear state before the next edge.
        rst1 = 1'b1;
        #2;
        sb1.delete();
        checks++;
        if (bus1.Level !== 5'd0 || bus1.EMPTY !== 1'b1 || bus1.ALMOST_EMPTY !== 1'b1
            || bus1.FULL !== 1'b0 || bus1.ALMOST_FULL !== 1'b0 || bus1.dataOut !== 8'h00) begin
            errors++;
            $display("FAIL fwft_async_reset: got level=%0d e=%b ae=%b f=%b af=%b data=%h want 0/1/1/0/0/00",
                     bus1.Level, bus1.EMPTY, bus1.ALMOST_EMPTY, bus1.FULL, bus1.ALMOST_FULL, bus1.dataOut);
        end
        @(posedge Clk);
        #1;
        rst1 = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        hold0 = '0;
        ov0 = 1'b0;
        un0 = 1'b0;
        rst0 = 1'b0;
        rst1 = 1'b0;
        bus0.WR = 1'b0; bus0.RD = 1'b0; bus0.ClrErr = 1'b0; bus0.dataIn = '0;
        bus1.WR = 1'b0; bus1.RD = 1'b0; bus1.ClrErr = 1'b0; bus1.dataIn = '0;
        #2;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_errors();
        test_fwft();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
